// File: rtl/alu_serial_driver.sv
// Bit-serial driver for a 1-bit ALU slice: one operand bit per cycle, LSB first, carry chained through a register.
// Optional feature: define OVERFLOW_FLAG_EN to add the signed-overflow output.
module alu_serial_driver #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic [3:0]       aluOp,
`ifdef OVERFLOW_FLAG_EN
   output logic             overflow,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] resultOut,
   output logic             carryOutFinal,
   output logic             zero,
   output logic             sliceA,
   output logic             sliceB,
   output logic             sliceAInvert,
   output logic             sliceBInvert,
   output logic             sliceCarryIn,
   output logic [1:0]       sliceOperation,
   input  logic             sliceResult,
   input  logic             sliceCarryOut
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} stateType;

   stateType         stateReg, stateNext;
   logic [CW-1:0]    cntReg;
   logic [WIDTH-1:0] aReg, bReg;
   logic [3:0]       opReg;
   logic             carryReg;
   logic [WIDTH-1:0] resultReg;
   logic             carryOutReg;
   logic             zeroReg;
   logic [WIDTH-1:0] captureEn;
   logic             accept;
   logic             runActive;
   logic             lastBit;
`ifdef OVERFLOW_FLAG_EN
   logic             overflowReg;
`endif

   assign accept    = (stateReg == IDLE) && start;
   assign runActive = (stateReg == RUN);
   assign lastBit   = runActive && (cntReg == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg <= IDLE;
      end else begin
         stateReg <= stateNext;
      end
   end

   // Next state plus slice drives; drives stay at 0 outside RUN.
   always_comb begin
      stateNext      = stateReg;
      sliceA         = 1'b0;
      sliceB         = 1'b0;
      sliceAInvert   = 1'b0;
      sliceBInvert   = 1'b0;
      sliceCarryIn   = 1'b0;
      sliceOperation = 2'b00;
      case (stateReg)
         IDLE: begin
            if (start) begin
               stateNext = RUN;
            end
         end
         RUN: begin
            sliceA         = aReg[cntReg];
            sliceB         = bReg[cntReg];
            sliceAInvert   = opReg[3];
            sliceBInvert   = opReg[2];
            sliceOperation = opReg[1:0];
            // First bit of SUB gets bInvert as carry-in so the slice computes a + ~b + 1.
            if (cntReg == '0) begin
               sliceCarryIn = (opReg[1:0] == 2'b10) && opReg[2];
            end else begin
               sliceCarryIn = carryReg;
            end
            if (cntReg == LAST) begin
               stateNext = DONE;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : genCapture
         assign captureEn[gi] = runActive && (cntReg == CW'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cntReg      <= '0;
         aReg        <= '0;
         bReg        <= '0;
         opReg       <= '0;
         carryReg    <= 1'b0;
         resultReg   <= '0;
         carryOutReg <= 1'b0;
         zeroReg     <= 1'b0;
      end else if (accept) begin
         cntReg      <= '0;
         aReg        <= opA;
         bReg        <= opB;
         opReg       <= aluOp;
         carryReg    <= 1'b0;
         resultReg   <= '0;
         carryOutReg <= 1'b0;
         zeroReg     <= 1'b0;
      end else if (runActive) begin
         carryReg  <= sliceCarryOut;
         resultReg <= (resultReg & ~captureEn) | ({WIDTH{sliceResult}} & captureEn);
         if (lastBit) begin
            cntReg      <= '0;
            carryOutReg <= sliceCarryOut;
            zeroReg     <= ({sliceResult, resultReg[WIDTH-2:0]} == '0);
         end else begin
            cntReg <= cntReg + 1'b1;
         end
      end
   end

`ifdef OVERFLOW_FLAG_EN
   // Signed overflow: carry into the MSB differs from carry out of it; meaningful for add/sub only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflowReg <= 1'b0;
      end else if (accept) begin
         overflowReg <= 1'b0;
      end else if (lastBit) begin
         overflowReg <= (opReg[1:0] == 2'b10) && (sliceCarryIn ^ sliceCarryOut);
      end
   end

   assign overflow = overflowReg;
`endif

   assign busy          = (stateReg != IDLE);
   assign done          = (stateReg == DONE);
   assign resultOut     = resultReg;
   assign carryOutFinal = carryOutReg;
   assign zero          = zeroReg;

endmodule
